// File: rtl/forwarding_scoreboard.sv
// Forwarding and load-use hazard unit for the EX stage.
// A shift-register scoreboard tracks in-flight destination registers, one
// entry per post-EX stage. Each source operand picks the youngest matching
// entry as its forward source. A load-use stall is raised when that youngest
// match cannot supply its data yet.

// Per-operand match: scans entries youngest first.
// Returns the forward select and whether the winning entry is not ready.
module forwarding_scoreboard_match #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 3,
    parameter int SEL_W  = $clog2(DEPTH + 1)
) (
    input  logic [DEPTH-1:0]             ent_wr,
    input  logic [DEPTH-1:0]             ent_ready,
    input  logic [DEPTH-1:0][ADDR_W-1:0] ent_rd,
    input  logic [ADDR_W-1:0]            src,
    output logic [SEL_W-1:0]             sel,
    output logic                         blocked
);

    // Youngest match wins. A younger unready entry masks any older ready one.
    // Register 0 is hard-wired, so it never matches.
    always_comb begin
        logic found;
        sel     = '0;
        blocked = 1'b0;
        found   = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!found && ent_wr[k] && (ent_rd[k] != '0) && (ent_rd[k] == src)) begin
                found   = 1'b1;
                sel     = SEL_W'(k + 1);
                blocked = ~ent_ready[k];
            end
        end
    end

endmodule

module forwarding_scoreboard #(
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 3,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    parameter int SEL_W    = $clog2(DEPTH + 1),
    parameter int CNT_W    = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      hold_i,
    input  logic                      flush_i,
    input  logic                      ex_valid_i,
    input  logic                      ex_regwrite_i,
    input  logic                      ex_is_load_i,
    input  logic [ADDR_W-1:0]         ex_rd_i,
    input  logic [NUM_SRC*ADDR_W-1:0] ex_src_i,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o,
    output logic                      stall_o,
    output logic [CNT_W-1:0]          stall_cnt_o
);

    // Scoreboard: entry 0 is the youngest (EX/MEM), entry DEPTH-1 the oldest.
    logic [DEPTH-1:0]             ent_wr;
    logic [DEPTH-1:0]             ent_ld;
    logic [DEPTH-1:0][ADDR_W-1:0] ent_rd;
    logic [DEPTH-1:0]             ent_ready;

    logic [NUM_SRC-1:0]           op_blocked;
    logic                         capture;
    logic [CNT_W-1:0]             cnt;

    // Load data only becomes forwardable from entry LOAD_LAT onward;
    // non-load results are forwardable from every entry.
    genvar gk;
    generate
        for (gk = 0; gk < DEPTH; gk++) begin : g_ready
            if (gk >= LOAD_LAT) begin : g_late
                assign ent_ready[gk] = 1'b1;
            end else begin : g_early
                assign ent_ready[gk] = ~ent_ld[gk];
            end
        end
    endgenerate

    // One match unit per source operand.
    genvar gn;
    generate
        for (gn = 0; gn < NUM_SRC; gn++) begin : g_op
            forwarding_scoreboard_match #(
                .ADDR_W (ADDR_W),
                .DEPTH  (DEPTH),
                .SEL_W  (SEL_W)
            ) u_match (
                .ent_wr    (ent_wr),
                .ent_ready (ent_ready),
                .ent_rd    (ent_rd),
                .src       (ex_src_i[gn*ADDR_W +: ADDR_W]),
                .sel       (fwd_sel_o[gn*SEL_W +: SEL_W]),
                .blocked   (op_blocked[gn])
            );
        end
    endgenerate

    // A squashed or empty EX slot never stalls; flush also wins over stall.
    assign stall_o = ex_valid_i & ~flush_i & (|op_blocked);

    // Stall or flush injects a bubble instead of the EX instruction.
    assign capture = ~stall_o & ~flush_i;

    // Scoreboard shift: entries age by one stage on every unfrozen edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ent_wr <= '0;
            ent_ld <= '0;
            ent_rd <= '0;
        end else if (!hold_i) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                ent_wr[k] <= ent_wr[k-1];
                ent_ld[k] <= ent_ld[k-1];
                ent_rd[k] <= ent_rd[k-1];
            end
            if (capture) begin
                ent_wr[0] <= ex_valid_i & ex_regwrite_i;
                ent_ld[0] <= ex_is_load_i;
                ent_rd[0] <= ex_rd_i;
            end else begin
                ent_wr[0] <= 1'b0;
                ent_ld[0] <= 1'b0;
                ent_rd[0] <= '0;
            end
        end
    end

    // Stall cycle counter, saturating at all-ones.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (!hold_i && stall_o && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign stall_cnt_o = cnt;

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Self-checking bench for forwarding_scoreboard.
// Three instances share one stimulus stream: default parameters,
// LOAD_LAT=0, and CNT_W=2 for counter saturation.
module tb_forwarding_scoreboard;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       hold_i;
    logic       flush_i;
    logic       ex_valid_i;
    logic       ex_regwrite_i;
    logic       ex_is_load_i;
    logic [4:0] ex_rd_i;
    logic [9:0] ex_src_i;

    logic [3:0]  sel0, sel1, sel2;
    logic        stall0, stall1, stall2;
    logic [15:0] cnt0, cnt1;
    logic [1:0]  cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    forwarding_scoreboard u_dut0 (
        .clk_i(clk_i), .rst_i(rst_i), .hold_i(hold_i), .flush_i(flush_i),
        .ex_valid_i(ex_valid_i), .ex_regwrite_i(ex_regwrite_i), .ex_is_load_i(ex_is_load_i),
        .ex_rd_i(ex_rd_i), .ex_src_i(ex_src_i),
        .fwd_sel_o(sel0), .stall_o(stall0), .stall_cnt_o(cnt0)
    );

    forwarding_scoreboard #(.LOAD_LAT(0)) u_dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .hold_i(hold_i), .flush_i(flush_i),
        .ex_valid_i(ex_valid_i), .ex_regwrite_i(ex_regwrite_i), .ex_is_load_i(ex_is_load_i),
        .ex_rd_i(ex_rd_i), .ex_src_i(ex_src_i),
        .fwd_sel_o(sel1), .stall_o(stall1), .stall_cnt_o(cnt1)
    );

    forwarding_scoreboard #(.CNT_W(2)) u_dut2 (
        .clk_i(clk_i), .rst_i(rst_i), .hold_i(hold_i), .flush_i(flush_i),
        .ex_valid_i(ex_valid_i), .ex_regwrite_i(ex_regwrite_i), .ex_is_load_i(ex_is_load_i),
        .ex_rd_i(ex_rd_i), .ex_src_i(ex_src_i),
        .fwd_sel_o(sel2), .stall_o(stall2), .stall_cnt_o(cnt2)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_ex(input logic v, input logic rw, input logic ld,
                          input logic [4:0] rd, input logic [4:0] s0, input logic [4:0] s1);
        ex_valid_i    = v;
        ex_regwrite_i = rw;
        ex_is_load_i  = ld;
        ex_rd_i       = rd;
        ex_src_i      = {s1, s0};
    endtask

    task automatic do_reset();
        hold_i  = 1'b0;
        flush_i = 1'b0;
        set_ex(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        rst_i = 1'b1;
        next_cycle();
        next_cycle();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            settle();
            checks++;
            if (sel0 !== 4'd0 || stall0 !== 1'b0 || cnt0 !== 16'd0) begin
                errors++;
                $display("FAIL reset_idle: sel=%0d stall=%0d cnt=%0d expected 0/0/0", sel0, stall0, cnt0);
            end
            next_cycle();
        end
        // Async clear of a live forward between edges.
        set_ex(1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 5'd0);
        next_cycle();
        set_ex(1'b1, 1'b0, 1'b0, 5'd0, 5'd3, 5'd0);
        settle();
        checks++;
        if (sel0 !== 4'd1) begin
            errors++;
            $display("FAIL reset_pre_async: sel=%0d expected 1", sel0);
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if (sel0 !== 4'd0) begin
            errors++;
            $display("FAIL reset_async_sel: sel=%0d expected 0", sel0);
        end
        rst_i = 1'b0;
        // Async clear in the middle of a stall.
        next_cycle();
        set_ex(1'b1, 1'b1, 1'b1, 5'd5, 5'd0, 5'd0);
        next_cycle();
        set_ex(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0);
        settle();
        checks++;
        if (stall0 !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_stall: stall=%0d expected 1", stall0);
        end
        next_cycle();
        #2;
        rst_i = 1'b1;
        #1;
        checks++;
        if (stall0 !== 1'b0 || sel0 !== 4'd0 || cnt0 !== 16'd0) begin
            errors++;
            $display("FAIL reset_async_stall: stall=%0d sel=%0d cnt=%0d expected 0/0/0", stall0, sel0, cnt0);
        end
        rst_i = 1'b0;
        next_cycle();
    endtask

    task automatic test_alu_chain();
        do_reset();
        set_ex(1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 5'd0);
        next_cycle();
        set_ex(1'b1, 1'b0, 1'b0, 5'd0, 5'd3, 5'd0);
        settle();
        checks++;
        if (sel0[1:0] !== 2'd1) begin
            errors++;
            $display("FAIL alu_sel1: sel0=%0d expected 1", sel0[1:0]);
        end
        next_cycle();
        set_ex(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd3);
        settle();
        checks++;
        if (sel0[3:2] !== 2'd2) begin
            errors++;
            $display("FAIL alu_sel2: sel1=%0d expected 2", sel0[3:2]);
        end
        next_cycle();
        set_ex(1'b1, 1'b0, 1'b0, 5'd0, 5'd3, 5'd3);
        settle();
        checks++;
        if (sel0 !== 4'b1111) begin
            errors++;
            $display("FAIL alu_sel3: sel=%0h expected f", sel0);
        end
        next_cycle();
        settle();
        checks++;
        if (sel0 !== 4'd0) begin
            errors++;
            $display("FAIL alu_sel_gone: sel=%0h expected 0", sel0);
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        do_reset();
        set_ex(1'b1, 1'b1, 1'b1, 5'd5, 5'd0, 5'd0);
        next_cycle();
        set_ex(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0);
        settle();
        checks++;
        if (stall0 !== 1'b1) begin
            errors++;
            $display("FAIL load_use_stall: stall=%0d expected 1", stall0);
        end
        checks++;
        if (stall1 !== 1'b0 || sel1[1:0] !== 2'd1) begin
            errors++;
            $display("FAIL load_lat0: stall=%0d sel=%0d expected 0/1", stall1, sel1[1:0]);
        end
        next_cycle();
        settle();
        checks++;
        if (stall0 !== 1'b0 || sel0[1:0] !== 2'd2 || cnt0 !== 16'd1) begin
            errors++;
            $display("FAIL load_use_after: stall=%0d sel=%0d cnt=%0d expected 0/2/1", stall0, sel0[1:0], cnt0);
        end
        checks++;
        if (cnt1 !== 16'd0) begin
            errors++;
            $display("FAIL load_lat0_cnt: cnt=%0d expected 0", cnt1);
        end
        next_cycle();
    endtask

    task automatic test_priority();
        do_reset();
        set_ex(1'b1, 1'b1, 1'b0, 5'd4, 5'd0, 5'd0);
        next_cycle();
        next_cycle();
        set_ex(1'b1, 1'b0, 1'b0, 5'd0, 5'd4, 5'd0);
        settle();
        checks++;
        if (sel0[1:0] !== 2'd1) begin
            errors++;
            $display("FAIL prio_youngest: sel=%0d expected 1", sel0[1:0]);
        end
        next_cycle();
        set_ex(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        next_cycle();
        set_ex(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        settle();
        checks++;
        if (sel0 !== 4'd0) begin
            errors++;
            $display("FAIL prio_zero: sel=%0d expected 0", sel0);
        end
        next_cycle();
        set_ex(1'b1, 1'b0, 1'b0, 5'd6, 5'd0, 5'd0);
        next_cycle();
        set_ex(1'b1, 1'b0, 1'b0, 5'd0, 5'd6, 5'd6);
        settle();
        checks++;
        if (sel0 !== 4'd0) begin
            errors++;
            $display("FAIL prio_nowrite: sel=%0d expected 0", sel0);
        end
        // Younger unready load must not be overridden by an older ready ALU write.
        next_cycle();
        set_ex(1'b1, 1'b1, 1'b0, 5'd9, 5'd0, 5'd0);
        next_cycle();
        set_ex(1'b1, 1'b1, 1'b1, 5'd9, 5'd0, 5'd0);
        next_cycle();
        set_ex(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd9);
        settle();
        checks++;
        if (stall0 !== 1'b1) begin
            errors++;
            $display("FAIL prio_unready: stall=%0d expected 1", stall0);
        end
        next_cycle();
    endtask

    task automatic test_flush_hold();
        do_reset();
        set_ex(1'b1, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0);
        flush_i = 1'b1;
        next_cycle();
        flush_i = 1'b0;
        set_ex(1'b1, 1'b0, 1'b0, 5'd0, 5'd7, 5'd7);
        settle();
        checks++;
        if (sel0 !== 4'd0) begin
            errors++;
            $display("FAIL flush_squash: sel=%0d expected 0", sel0);
        end
        next_cycle();
        // Flush during a would-be load-use stall: no stall.
        set_ex(1'b1, 1'b1, 1'b1, 5'd10, 5'd0, 5'd0);
        next_cycle();
        set_ex(1'b1, 1'b0, 1'b0, 5'd0, 5'd10, 5'd0);
        flush_i = 1'b1;
        settle();
        checks++;
        if (stall0 !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall: stall=%0d expected 0", stall0);
        end
        next_cycle();
        flush_i = 1'b0;
        set_ex(1'b1, 1'b1, 1'b0, 5'd8, 5'd0, 5'd0);
        next_cycle();
        set_ex(1'b1, 1'b0, 1'b0, 5'd0, 5'd8, 5'd0);
        hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++;
            if (sel0[1:0] !== 2'd1) begin
                errors++;
                $display("FAIL hold_sel: sel=%0d expected 1", sel0[1:0]);
            end
            next_cycle();
        end
        hold_i = 1'b0;
        next_cycle();
        settle();
        checks++;
        if (sel0[1:0] !== 2'd2) begin
            errors++;
            $display("FAIL hold_release: sel=%0d expected 2", sel0[1:0]);
        end
        // Counter frozen while stalled under hold.
        next_cycle();
        set_ex(1'b1, 1'b1, 1'b1, 5'd11, 5'd0, 5'd0);
        next_cycle();
        set_ex(1'b1, 1'b0, 1'b0, 5'd0, 5'd11, 5'd0);
        hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++;
            if (stall0 !== 1'b1 || cnt0 !== 16'd0) begin
                errors++;
                $display("FAIL hold_cnt: stall=%0d cnt=%0d expected 1/0", stall0, cnt0);
            end
            next_cycle();
        end
        hold_i = 1'b0;
        next_cycle();
        settle();
        checks++;
        if (cnt0 !== 16'd1 || stall0 !== 1'b0) begin
            errors++;
            $display("FAIL hold_cnt_release: cnt=%0d stall=%0d expected 1/0", cnt0, stall0);
        end
        next_cycle();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_ex(1'b1, 1'b1, 1'b1, 5'd12, 5'd0, 5'd0);
            next_cycle();
            set_ex(1'b1, 1'b0, 1'b0, 5'd0, 5'd12, 5'd0);
            next_cycle();
            next_cycle();
        end
        settle();
        checks++;
        if (cnt2 !== 2'd3) begin
            errors++;
            $display("FAIL cnt_saturate: cnt=%0d expected 3", cnt2);
        end
        checks++;
        if (cnt0 !== 16'd5) begin
            errors++;
            $display("FAIL cnt_wide: cnt=%0d expected 5", cnt0);
        end
        next_cycle();
    endtask

    // Random stimulus against a reference model: per instance, an age-ordered
    // list of in-flight writes (index 0 = youngest).
    task automatic test_random();
        int m_wr [3][3];
        int m_ld [3][3];
        int m_rd [3][3];
        int m_cnt [3];
        int lat [3];
        int cmax [3];
        int src [2];
        int exp_sel [3];
        int exp_stall [3];
        int got_sel, got_stall, got_cnt;
        lat  = '{1, 0, 1};
        cmax = '{65535, 65535, 3};
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0;
            for (int k = 0; k < 3; k++) begin
                m_wr[i][k] = 0; m_ld[i][k] = 0; m_rd[i][k] = 0;
            end
        end
        do_reset();
        for (int c = 0; c < 400; c++) begin
            src[0] = int'($urandom_range(0, 7));
            src[1] = int'($urandom_range(0, 7));
            set_ex(1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 3) != 0),
                   1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                   5'(src[0]), 5'(src[1]));
            flush_i = ($urandom_range(0, 7) == 0);
            hold_i  = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < 3; i++) begin
                int blocked;
                exp_sel[i] = 0;
                blocked = 0;
                for (int n = 0; n < 2; n++) begin
                    for (int k = 0; k < 3; k++) begin
                        if (m_wr[i][k] != 0 && m_rd[i][k] != 0 && m_rd[i][k] == src[n]) begin
                            exp_sel[i] += (k + 1) << (2 * n);
                            if (m_ld[i][k] != 0 && k < lat[i]) blocked = 1;
                            break;
                        end
                    end
                end
                exp_stall[i] = (ex_valid_i && !flush_i && blocked != 0) ? 1 : 0;
            end
            settle();
            for (int i = 0; i < 3; i++) begin
                got_sel   = (i == 0) ? int'(sel0)   : (i == 1) ? int'(sel1)   : int'(sel2);
                got_stall = (i == 0) ? int'(stall0) : (i == 1) ? int'(stall1) : int'(stall2);
                got_cnt   = (i == 0) ? int'(cnt0)   : (i == 1) ? int'(cnt1)   : int'(cnt2);
                checks++;
                if (got_sel !== exp_sel[i] || got_stall !== exp_stall[i] || got_cnt !== m_cnt[i]) begin
                    errors++;
                    $display("FAIL random[%0d] inst%0d: sel=%0h stall=%0d cnt=%0d expected %0h/%0d/%0d",
                             c, i, got_sel, got_stall, got_cnt, exp_sel[i], exp_stall[i], m_cnt[i]);
                end
            end
            // Advance the model as the edge would.
            if (!hold_i) begin
                for (int i = 0; i < 3; i++) begin
                    for (int k = 2; k >= 1; k--) begin
                        m_wr[i][k] = m_wr[i][k-1];
                        m_ld[i][k] = m_ld[i][k-1];
                        m_rd[i][k] = m_rd[i][k-1];
                    end
                    if (exp_stall[i] != 0 || flush_i) begin
                        m_wr[i][0] = 0; m_ld[i][0] = 0; m_rd[i][0] = 0;
                    end else begin
                        m_wr[i][0] = (ex_valid_i && ex_regwrite_i) ? 1 : 0;
                        m_ld[i][0] = int'(ex_is_load_i);
                        m_rd[i][0] = int'(ex_rd_i);
                    end
                    if (exp_stall[i] != 0 && m_cnt[i] < cmax[i]) m_cnt[i]++;
                end
            end
            next_cycle();
        end
        hold_i  = 1'b0;
        flush_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        hold_i = 1'b0;
        flush_i = 1'b0;
        set_ex(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        #1;
        test_reset();
        test_alu_chain();
        test_load_use();
        test_priority();
        test_flush_hold();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
